// File: rtl/ser_to_par_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver and its bit counter.
// Buffer FSM encoding, shift-direction constants and the default word width.
package ser_to_par_rx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/ser_to_par_rx_bit_counter.sv
// Wrapping bit counter: counts 0..MAX on enable, flags the terminal count.
// Shared with the transmitter side of the link.
module rx_bit_counter
    import ser_to_par_rx_pkg::*;
#(
    parameter int unsigned CW  = 3,
    parameter int unsigned MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc_c
);

    logic [CW-1:0] r_count;

    assign o_tc_c  = (r_count == CW'(MAX));
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc_c ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/ser_to_par_rx.sv
// Serial-to-parallel receiver: MSB- or LSB-first assembly into a one-word
// valid/ack buffer with sticky overrun. Optional parity bit via PARITY_CHECK_EN.
module ser_to_par_rx
    import ser_to_par_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             DIR,
    input  logic             QACK,
    input  logic             OE,
    output logic [WIDTH-1:0] Q,
    output logic             QVALID,
`ifdef PARITY_CHECK_EN
    output logic             PERR,
`endif
    output logic             OVR
);

`ifdef PARITY_CHECK_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif

    logic [CW-1:0]    w_count;
    logic             w_tc;
    logic             w_done;
    logic             w_dir;
    logic             w_is_data;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_buf;
    logic             r_dir;
    logic             r_ovr;
    logic             w_load;
    logic             w_ovr_set;
    buf_state_e       r_state;
    buf_state_e       w_state_nxt;

    rx_bit_counter #(
        .CW  (CW),
        .MAX (LAST)
    ) u_bit_counter (
        .clk     (CLK),
        .rst     (RST),
        .i_en    (SVALID),
        .o_count (w_count),
        .o_tc_c  (w_tc)
    );

    assign w_done = SVALID && w_tc;
    // Direction is taken live on bit 0 and from the latch for the rest of the word.
    assign w_dir  = (w_count == '0) ? DIR : r_dir;

    always_comb begin
        w_sr_shift = r_sr;
        case (w_dir)
            DIR_MSB_FIRST: w_sr_shift = {r_sr[WIDTH-2:0], SIN};
            DIR_LSB_FIRST: w_sr_shift = {SIN, r_sr[WIDTH-1:1]};
        endcase
    end

`ifdef PARITY_CHECK_EN
    logic w_perr;
    logic r_perr;

    // The parity bit closes the frame but never enters the data register.
    assign w_is_data = !w_tc;
    assign w_word    = r_sr;
    assign w_perr    = (^r_sr) ^ SIN;
    assign PERR      = r_perr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= w_perr;
        end
    end
`else
    assign w_is_data = 1'b1;
    assign w_word    = w_sr_shift;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr  <= '0;
            r_dir <= DIR_MSB_FIRST;
        end else if (SVALID) begin
            if (w_count == '0) begin
                r_dir <= DIR;
            end
            if (w_is_data) begin
                r_sr <= w_sr_shift;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer FSM: load when empty or being acked, otherwise drop and flag overrun.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_done && QACK) begin
                    w_load = 1'b1;
                end else if (w_done) begin
                    w_ovr_set = 1'b1;
                end else if (QACK) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_buf <= '0;
            r_ovr <= 1'b0;
        end else begin
            if (w_load) begin
                r_buf <= w_word;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign QVALID = (r_state == FULL);
    assign OVR    = r_ovr;
    assign Q      = OE ? {WIDTH{1'bz}} : r_buf;

endmodule

// File: tb/tb_ser_to_par_rx.sv
// Bench for ser_to_par_rx: directed vector table, hand-written reset sequences,
// and random traffic against a frame-level reference model. Honours PARITY_CHECK_EN.
module tb_ser_to_par_rx;

    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         svalid;
    logic         dir;
    logic         qack;
    logic         oe;
    wire  [W-1:0] q;
    logic         qvalid;
    logic         ovr;
    logic         perr;

    int checks = 0;
    int errors = 0;

    ser_to_par_rx #(.WIDTH(W), .CW(3)) dut (
        .CLK    (clk),
        .RST    (rst),
        .SIN    (sin),
        .SVALID (svalid),
        .DIR    (dir),
        .QACK   (qack),
        .OE     (oe),
        .Q      (q),
        .QVALID (qvalid),
`ifdef PARITY_CHECK_EN
        .PERR   (perr),
`endif
        .OVR    (ovr)
    );

`ifndef PARITY_CHECK_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    typedef struct {
        logic         sin, sv, dir, ack, oe;
        logic [W-1:0] q;
        logic         qv, ovr, perr;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: bits of the frame in flight plus buffer contents.
    logic         m_bits[$];
    logic         m_dir;
    logic         m_valid;
    logic [W-1:0] m_buf;
    logic         m_ovr;
    logic         m_perr;

    task automatic add(input logic s, v, d, a, o, input logic [W-1:0] eq,
                       input logic eqv, eovr, eperr);
        vec_t r;
        r.sin = s; r.sv = v; r.dir = d; r.ack = a; r.oe = o;
        r.q = eq; r.qv = eqv; r.ovr = eovr; r.perr = eperr;
        tbl.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, v, d, a, o);
        sin = s; svalid = v; dir = d; qack = a; oe = o;
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir = 1'b0; m_valid = 1'b0; m_buf = '0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_step(input logic s, v, d, a);
        logic         done;
        logic [W-1:0] w;
        logic         p;
        done = 1'b0; w = '0; p = 1'b0;
        if (v) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(s);
            if (m_bits.size() == FL) begin
                for (int i = 0; i < W; i++) begin
                    if (m_dir) w[i] = m_bits[i];
                    else       w[W-1-i] = m_bits[i];
                end
                for (int i = 0; i < FL; i++) p = p ^ m_bits[i];
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || a) begin
                m_buf = w; m_perr = p; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (a) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic send_msb(input logic [FL-1:0] bits);
        for (int i = FL - 1; i >= 0; i--) begin
            drive(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_q", 0, 32'(q), 32'h0);
        chk("rst_qvalid", 0, 32'(qvalid), 32'h0);
        chk("rst_ovr", 0, 32'(ovr), 32'h0);
        tick();
        tick();
        rst = 1'b0;

`ifndef PARITY_CHECK_EN
        // MSB-first 1010, then ack
        add(1,1,0,0,0, 4'b0000,0,0,0);
        add(0,1,0,0,0, 4'b0000,0,0,0);
        add(1,1,0,0,0, 4'b0000,0,0,0);
        add(0,1,0,0,0, 4'b1010,1,0,0);
        add(0,0,0,1,0, 4'b1010,0,0,0);
        // LSB-first 0,1,1,1 with gaps and DIR flipped mid-word
        add(0,1,1,0,0, 4'b1010,0,0,0);
        add(0,0,1,0,0, 4'b1010,0,0,0);
        add(1,1,1,0,0, 4'b1010,0,0,0);
        add(0,0,0,0,0, 4'b1010,0,0,0);
        add(1,1,0,0,0, 4'b1010,0,0,0);
        add(1,0,0,0,0, 4'b1010,0,0,0);
        add(1,1,0,0,0, 4'b1110,1,0,0);
        // OE high releases the bus, OE low restores it
        add(0,0,0,0,1, 4'b1110,1,0,0);
        add(0,0,0,0,0, 4'b1110,1,0,0);
        add(0,0,0,1,0, 4'b1110,0,0,0);
        // 1010 buffered, 0101 overruns, 1100 lands with ack
        add(1,1,0,0,0, 4'b1110,0,0,0);
        add(0,1,0,0,0, 4'b1110,0,0,0);
        add(1,1,0,0,0, 4'b1110,0,0,0);
        add(0,1,0,0,0, 4'b1010,1,0,0);
        add(0,1,0,0,0, 4'b1010,1,0,0);
        add(1,1,0,0,0, 4'b1010,1,0,0);
        add(0,1,0,0,0, 4'b1010,1,0,0);
        add(1,1,0,0,0, 4'b1010,1,1,0);
        add(1,1,0,0,0, 4'b1010,1,1,0);
        add(1,1,0,0,0, 4'b1010,1,1,0);
        add(0,1,0,0,0, 4'b1010,1,1,0);
        add(0,1,0,1,0, 4'b1100,1,1,0);
        add(0,0,0,1,0, 4'b1100,0,1,0);
        add(0,0,0,1,0, 4'b1100,0,1,0);
`else
        // 1011 with correct parity, then with wrong parity
        add(1,1,0,0,0, 4'b0000,0,0,0);
        add(0,1,0,0,0, 4'b0000,0,0,0);
        add(1,1,0,0,0, 4'b0000,0,0,0);
        add(1,1,0,0,0, 4'b0000,0,0,0);
        add(1,1,0,0,0, 4'b1011,1,0,0);
        add(0,0,0,1,0, 4'b1011,0,0,0);
        add(1,1,1,0,0, 4'b1011,0,0,0);
        add(0,1,1,0,0, 4'b1011,0,0,0);
        add(1,1,0,0,0, 4'b1011,0,0,0);
        add(1,1,0,0,0, 4'b1011,0,0,0);
        add(0,1,0,0,0, 4'b1101,1,0,1);
        add(0,0,0,0,1, 4'b1101,1,0,1);
        add(0,0,0,0,0, 4'b1101,1,0,1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sin, tbl[i].sv, tbl[i].dir, tbl[i].ack, tbl[i].oe);
            tick();
            if (tbl[i].oe) begin
                checks++;
                if (q === tbl[i].q) begin
                    errors++;
                    $display("FAIL vec_q_hiz[%0d]: got %0h expected bus released", i, q);
                end
            end else begin
                chk("vec_q", i, 32'(q), 32'(tbl[i].q));
            end
            chk("vec_qvalid", i, 32'(qvalid), 32'(tbl[i].qv));
            chk("vec_ovr", i, 32'(ovr), 32'(tbl[i].ovr));
`ifdef PARITY_CHECK_EN
            chk("vec_perr", i, 32'(perr), 32'(tbl[i].perr));
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-word with a non-zero buffer
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst_q", 0, 32'(q), 32'h0);
        chk("async_rst_qvalid", 0, 32'(qvalid), 32'h0);
        chk("async_rst_ovr", 0, 32'(ovr), 32'h0);
        chk("async_rst_perr", 0, 32'(perr), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        send_msb(FL'(5'b01100 >> (5 - FL)));
        chk("fresh_q", 0, 32'(q), 32'h6);
        chk("fresh_qvalid", 0, 32'(qvalid), 32'h1);
        chk("fresh_ovr", 0, 32'(ovr), 32'h0);
        chk("fresh_perr", 0, 32'(perr), 32'h0);

        // Random traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom), 1'($urandom_range(0, 1)), 1'($urandom),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
            tick();
            model_step(sin, svalid, dir, qack);
            if (!oe) chk("rnd_q", c, 32'(q), 32'(m_buf));
            chk("rnd_qvalid", c, 32'(qvalid), 32'(m_valid));
            chk("rnd_ovr", c, 32'(ovr), 32'(m_ovr));
`ifdef PARITY_CHECK_EN
            chk("rnd_perr", c, 32'(perr), 32'(m_perr));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_to_par_rx.md
Name: ser_to_par_rx

Overview:
- Receiving end of the 4-bit universal shift-register link. Collects a serial bit stream, one bit per strobe, and reassembles it into parallel words.
- Accepts both sender shift modes: shift-left (MSB-first) and shift-right (LSB-first).
- Holds each completed word in an output buffer with a valid/acknowledge handshake. Drives the word on a tri-stateable parallel bus gated by active-low OE.
- Sits between the shift-register transmitter's serial pin and the downstream parallel consumer.

Parameters:
- WIDTH, 4, word width in bits (≥2).
- CW, 3, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- SIN  input  1  serial data bit.
- SVALID  input  1  SIN is sampled on this CLK edge.
- DIR  input  1  0 = MSB-first (sender shifting left), 1 = LSB-first (sender shifting right).
- QACK  input  1  consumer has taken the buffered word.
- OE  input  1  output enable, active-low.
- Q  output  WIDTH  buffered word; high-Z when OE=1.
- QVALID  output  1  buffer holds an unread word.
- OVR  output  1  sticky overrun flag.

Behaviour:
- Reset (RST=1, asynchronous): shift register=0, bit counter=0, output buffer=0, QVALID=0, OVR=0, buffer FSM=EMPTY. Q=0 when OE=0.
- DIR latch: DIR is sampled on the edge that accepts bit 0 of a word (counter=0 and SVALID=1). It is held for the rest of the word; DIR changes mid-word are ignored.
- Shift on SVALID=1:
  - dir=0: sr <= {sr[WIDTH-2:0], SIN}. The first bit ends up in Q[WIDTH-1].
  - dir=1: sr <= {SIN, sr[WIDTH-1:1]}. The first bit ends up in Q[0].
  - Counter increments by 1.
- SVALID=0: shift register and counter hold. Gaps of any length between bits are legal.
- Word completion: an SVALID edge with counter=WIDTH-1.
  - Counter wraps to 0.
  - The assembled word, including the bit from this edge, goes to the buffer subject to the FSM below.
  - QVALID rises on that same edge, so it is visible in the cycle after the last bit is sampled. Latency is 1 cycle.
- Buffer FSM:
  - EMPTY: on completion, load buffer, go to FULL.
  - FULL, QACK=1 with no completion: go to EMPTY, QVALID=0 on the next cycle. The buffer contents are retained.
  - FULL, QACK=1 with completion on the same edge: load the new word, stay FULL, QVALID stays 1.
  - FULL, no QACK, completion: the new word is dropped, the buffer keeps the old word, OVR <= 1, stay FULL.
  - QACK while EMPTY: ignored.
- OVR is sticky; only RST clears it.
- Q is combinational from OE and the buffer: OE=1 gives all-Z, OE=0 gives the buffer. OE has no effect on state or QVALID.
- Reset mid-word discards the partial word. The next SVALID bit is bit 0 of a new word.
- Counter never exceeds WIDTH-1 (WIDTH with parity, see below).

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH+1 bits. The last bit is an even-parity bit over the WIDTH data bits and is not shifted into the data register.
  - Completion occurs at counter=WIDTH.
  - Extra output port PERR (1 bit) is loaded with the word; it is 1 when the XOR of all WIDTH+1 bits equals 1.
  - PERR follows the same buffer/drop rules as Q and resets to 0.
- Not defined: frame is WIDTH bits, no parity bit, and the PERR port does not exist.

Decomposition:
- Shared package/include holds:
  - buffer FSM state encoding: EMPTY=1'b0, FULL=1'b1.
  - direction constants: DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1.
  - default WIDTH.
- One natural sub-module, rx_bit_counter: a wrapping counter with enable, terminal-count output and async reset. It is reused by the transmitter side.

Test Plan:
- Reset check, OE=0: assert RST with the buffer non-zero mid-word → Q=0000, QVALID=0, OVR=0 immediately, without waiting for a clock edge.
- MSB-first word: DIR=0, OE=0, SIN=1,0,1,0 on 4 consecutive SVALID cycles → Q=1010, QVALID=1 one cycle after the 4th bit. Then QACK=1 for 1 cycle → QVALID=0, Q remains 1010.
- LSB-first word with gaps and a mid-word DIR flip: DIR=1 at bit 0, SIN=0,1,1,1 with idle cycles between bits, DIR toggled after bit 1 → Q=1110.
- Output enable: with Q=1110, OE=1 → Q=ZZZZ, QVALID unchanged; OE=0 → Q=1110.
- Overrun then simultaneous ack:
  - Word 1010 buffered; send 0101 with no QACK → Q=1010, OVR=1.
  - Next word 1100 completes on the same edge as QACK=1 → Q=1100, QVALID=1, OVR still 1.
- Parity and mid-word reset (PARITY_CHECK_EN build):
  - Frame 1,0,1,1 followed by parity bit 1 → Q=1011, PERR=0.
  - Frame 1,0,1,1 followed by parity bit 0 → PERR=1.
  - Pulse RST after 2 bits, then send 5 fresh bits → a clean word with no residue from before the reset.
